// File: rtl/rf_dump_reader_pkg.sv
// rf_dump_reader_pkg: regfile geometry shared by the dump reader, its port bundle and its users
package rf_dump_reader_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_dump_reader_if.sv
// rf_dump_reader_if: control, regfile read port and {index, value} record stream of the dump reader
interface rf_dump_reader_if
  import rf_dump_reader_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rf_ra;
  logic [DATA_W-1:0] rf_rd;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  modport master (
    input  start, abort, rf_rd, out_ready,
    output rf_ra, out_valid, out_addr, out_data, busy, done
  );
  modport slave (
    output start, abort, rf_rd, out_ready,
    input  rf_ra, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks regfile entries START_IDX..NUM_REGS-1 through one read port
// and streams each {index, value} record over a valid/ready port
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int START_IDX = 0
)(
  input logic              clk,
  input logic              rst,
  rf_dump_reader_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_hs;
  logic              w_last;
  assign w_hs          = r_valid && bus.out_ready;
  assign w_last        = r_idx == LAST_IDX;
  assign bus.rf_ra     = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.out_addr  = r_addr;
  assign bus.out_data  = r_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  // The record register is loaded only in FETCH, so it holds still through SEND back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= FIRST_IDX;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_idx   <= FIRST_IDX;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_addr  <= r_idx;
            r_data  <= bus.rf_rd;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: directed checks of the dump reader against a bypassing 32x32 regfile model
module tb_rf_dump_reader;
  import rf_dump_reader_pkg::*;
  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     load;
  logic     we;
  rf_addr_t wa;
  rf_data_t wd;
  rf_data_t rf     [32];
  rf_data_t exp_rf [32];
  int       n_chk = 0;
  int       n_fail = 0;
  int       exp_idx, rec_cnt, done_cnt;
  bit       mon_en = 1'b0;
  always #5 clk = ~clk;
  rf_dump_reader_if a_if();
  rf_dump_reader_if b_if();
  rf_dump_reader u_a (.clk(clk), .rst(rst), .bus(a_if));
  rf_dump_reader #(.NUM_REGS(4), .START_IDX(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + i;
    end else if (we) begin
      rf[wa] <= wd;
    end
  end
  assign a_if.rf_rd = (we && wa == a_if.rf_ra) ? wd : rf[a_if.rf_ra];
  assign b_if.rf_rd = (we && wa == b_if.rf_ra) ? wd : rf[b_if.rf_ra];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_if.done) done_cnt++;
      if (a_if.out_valid) begin
        chk("rec_addr", 64'(a_if.out_addr), 64'(exp_idx));
        chk("rec_data", 64'(a_if.out_data), 64'(exp_rf[exp_idx % 32]));
        if (a_if.out_ready) begin
          exp_idx++;
          rec_cnt++;
        end
      end
    end
  end
  task automatic clr();
    exp_idx  = 0;
    rec_cnt  = 0;
    done_cnt = 0;
  endtask
  task automatic pulse_start();
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
  endtask
  task automatic run_to_done(input int budget, input bit rnd, output int n);
    n = 0;
    do begin
      if (rnd) a_if.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end while (!a_if.done && n < budget);
    chk("done_seen", 64'(a_if.done), 64'd1);
    a_if.out_ready = 1'b1;
  endtask
  task automatic tail(input string tag);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk({tag, "_records"}, 64'(rec_cnt), 64'd32);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask
  initial begin
    int n, cnt, e;
    a_if.start = 0; a_if.abort = 0; a_if.out_ready = 0;
    b_if.start = 0; b_if.abort = 0; b_if.out_ready = 0;
    we = 0; wa = '0; wd = '0; load = 1;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'hA000_0000 + i;
    clr();
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 64'(a_if.out_valid), 64'd0);
    chk("rst_busy", 64'(a_if.busy), 64'd0);
    chk("rst_done", 64'(a_if.done), 64'd0);
    chk("rst_addr", 64'(a_if.out_addr), 64'd0);
    chk("rst_data", 64'(a_if.out_data), 64'd0);
    chk("rst_ra", 64'(a_if.rf_ra), 64'd0);
    chk("rst_ra_b", 64'(b_if.rf_ra), 64'd1);
    rst = 0; load = 0;
    @(posedge clk); #1;
    // full scan with the sink always ready
    mon_en = 1; a_if.out_ready = 1;
    pulse_start();
    chk("t1_busy_fetch", 64'(a_if.busy), 64'd1);
    chk("t1_valid_fetch", 64'(a_if.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_first_valid", 64'(a_if.out_valid), 64'd1);
    run_to_done(200, 0, n);
    chk("t1_done_lat", 64'(n + 1), 64'd64);
    chk("t1_busy_done", 64'(a_if.busy), 64'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 64'(a_if.done), 64'd0);
    tail("t1");
    // random back-pressure
    clr();
    pulse_start();
    run_to_done(500, 1, n);
    tail("t2");
    // CPU write bypassed into the FETCH of index 5
    clr();
    exp_rf[5] = 32'hDEAD_BEEF;
    pulse_start();
    repeat (10) @(posedge clk); #1;
    chk("t3_ra", 64'(a_if.rf_ra), 64'd5);
    we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    we = 0;
    chk("t3_addr5", 64'(a_if.out_addr), 64'd5);
    chk("t3_data5", 64'(a_if.out_data), 64'hDEAD_BEEF);
    run_to_done(200, 0, n);
    tail("t3");
    // abort while record 10 is stalled
    clr();
    pulse_start();
    repeat (20) @(posedge clk); #1;
    a_if.out_ready = 0;
    @(posedge clk); #1;
    chk("t4_valid10", 64'(a_if.out_valid), 64'd1);
    chk("t4_addr10", 64'(a_if.out_addr), 64'd10);
    a_if.abort = 1;
    @(posedge clk); #1;
    a_if.abort = 0;
    chk("t4_valid_drop", 64'(a_if.out_valid), 64'd0);
    chk("t4_busy_drop", 64'(a_if.busy), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("t4_no_done", 64'(done_cnt), 64'd0);
    chk("t4_partial", 64'(rec_cnt), 64'd10);
    clr();
    a_if.out_ready = 1;
    pulse_start();
    chk("t4_restart_ra", 64'(a_if.rf_ra), 64'd0);
    run_to_done(200, 0, n);
    tail("t4");
    // async reset mid-scan, then start pulses while busy
    clr();
    pulse_start();
    repeat (7) @(posedge clk); #1;
    mon_en = 0;
    #2 rst = 1;
    #1;
    chk("t5_valid", 64'(a_if.out_valid), 64'd0);
    chk("t5_busy", 64'(a_if.busy), 64'd0);
    chk("t5_addr", 64'(a_if.out_addr), 64'd0);
    chk("t5_data", 64'(a_if.out_data), 64'd0);
    chk("t5_ra", 64'(a_if.rf_ra), 64'd0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("t5_idle_busy", 64'(a_if.busy), 64'd0);
    chk("t5_idle_done", 64'(a_if.done), 64'd0);
    clr();
    mon_en = 1;
    pulse_start();
    repeat (9) @(posedge clk); #1;
    a_if.start = 1;
    @(posedge clk); #1;
    a_if.start = 0;
    repeat (20) @(posedge clk); #1;
    a_if.start = 1;
    @(posedge clk); #1;
    a_if.start = 0;
    run_to_done(200, 0, n);
    tail("t5");
    // short scan on the NUM_REGS=4, START_IDX=1 instance
    b_if.out_ready = 1;
    b_if.start = 1;
    @(posedge clk); #1;
    b_if.start = 0;
    n = 0; cnt = 0; e = 1;
    while (!b_if.done && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (b_if.out_valid) begin
        chk("t6_addr", 64'(b_if.out_addr), 64'(e));
        chk("t6_data", 64'(b_if.out_data), 64'(exp_rf[e % 32]));
        e++;
        cnt++;
      end
    end
    chk("t6_count", 64'(cnt), 64'd3);
    chk("t6_done_lat", 64'(n), 64'd6);
    chk("t6_busy", 64'(b_if.busy), 64'd0);
    chk("t6_last_ra", 64'(b_if.rf_ra), 64'd3);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
